axi_lite_cmd_master: RTL

AXI4-Lite initiator that converts single-beat command requests (address, data, strobe, direction) into AXI4-Lite read or write transactions and returns the slave's response on a separate response channel. It sits between internal control logic and any AXI4-Lite slave, including the decode-error responder used for unmapped address space. The block has one transaction outstanding at a time, and a cycle timeout guarantees a response even if the slave never answers.

---
 rtl/axi_lite_cmd_master.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: one outstanding single-beat read or write per command,
// with a cycle timeout that forces a response if the slave hangs.
module axi_lite_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        m_axi_aclk,
  input  logic        m_axi_aresetn,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  input  logic        cmd_write,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_write,
  output logic        rsp_timeout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_t;

  localparam logic [16:0] TO_LAST = 17'(TIMEOUT_CYCLES) - 17'd1;

  state_t      state_q;
  logic [16:0] cnt_q;
  logic        aw_done_q, w_done_q;
  logic        cmd_ready_q, rsp_valid_q, rsp_write_q, rsp_timeout_q;
  logic [31:0] rsp_rdata_q, awaddr_q, araddr_q, wdata_q;
  logic [1:0]  rsp_resp_q;
  logic [3:0]  wstrb_q;
  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, hs_any, in_axi, expire;

  assign aw_hs  = awvalid_q & m_axi_awready;
  assign w_hs   = wvalid_q  & m_axi_wready;
  assign b_hs   = bready_q  & m_axi_bvalid;
  assign ar_hs  = arvalid_q & m_axi_arready;
  assign r_hs   = rready_q  & m_axi_rvalid;
  assign hs_any = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  assign in_axi = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                  (state_q == RD_REQ) || (state_q == RD_DATA);
  // cnt_q holds the number of AXI-phase cycles already finished, so this is
  // true during the last permitted cycle and every cycle after it.
  assign expire = (TIMEOUT_CYCLES != 0) && (cnt_q >= TO_LAST);

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            awaddr_q    <= cmd_addr;
            araddr_q    <= cmd_addr;
            wdata_q     <= cmd_wdata;
            wstrb_q     <= cmd_wstrb;
            rsp_write_q <= cmd_write;
            cnt_q       <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            if (cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          aw_done_q <= aw_done_q | aw_hs;
          w_done_q  <= w_done_q | w_hs;
          if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            bready_q      <= 1'b0;
            rsp_resp_q    <= m_axi_bresp;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end
        end
        RD_REQ: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            rready_q      <= 1'b0;
            rsp_rdata_q   <= m_axi_rdata;
            rsp_resp_q    <= m_axi_rresp;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Abort overrides the per-state updates above, but any handshake seen
      // in the expiry cycle wins and the transaction carries on.
      if (in_axi) begin
        if (cnt_q != '1) cnt_q <= cnt_q + 17'd1;
        if (expire && !hs_any) begin
          awvalid_q     <= 1'b0;
          wvalid_q      <= 1'b0;
          bready_q      <= 1'b0;
          arvalid_q     <= 1'b0;
          rready_q      <= 1'b0;
          rsp_timeout_q <= 1'b1;
          rsp_resp_q    <= 2'b10;
          rsp_rdata_q   <= '0;
          rsp_valid_q   <= 1'b1;
          state_q       <= RESP;
        end
      end
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign rsp_valid     = rsp_valid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
endmodule
